vdp_bus_bridge: RTL

VDP_BUS_BRIDGE -- requirements
Module: vdp_bus_bridge

---
 rtl/vdp_bus_bridge.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vdp_bus_bridge.sv
// rtl/vdp_bus_bridge.sv - CPU request queue and access sequencer in front of a VDP port
//
// Accepts CPU read/write requests into a small FIFO and plays them out one at a
// time onto the VDP's mode/strobe/data pins. VRAM (mode 10) accesses are followed
// by an idle gap so the VDP's VRAM slot can complete before the next access.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   req_valid/req_ready                 request handshake (req_ready is combinational)
//   req_write, req_mode, req_data       request fields: direction, VDP mode, write data
//   rsp_valid, rsp_data                 one-cycle read response pulse and held read data
//   busy                                queue non-empty or sequencer active (combinational)
//   vdp_mode, vdp_read, vdp_write       registered VDP control outputs
//   vdp_data_in                         registered write data to the VDP
//   vdp_data_out                        read data from the VDP
module vdp_bus_bridge #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int VRAM_GAP      = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_mode,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [1:0] vdp_mode,
    output logic       vdp_read,
    output logic       vdp_write,
    output logic [7:0] vdp_data_in,
    input  logic [7:0] vdp_data_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t state, next_state;

    // Request FIFO: entry = {write, mode[1:0], data[7:0]}
    logic [10:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [10:0]      head;
    logic             push;
    logic             pop;

    // Operation currently being sequenced
    logic       op_write;
    logic [1:0] op_mode;
    logic [7:0] op_data;

    // Cycles spent in the current state; cleared on every state change
    logic [CNT_W-1:0] cnt;

    assign req_ready = !reset && (count != (PTR_W+1)'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_IDLE) && (count != '0);
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (count != '0) || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_write, req_mode, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                next_state = S_STROBE;
            end
            S_STROBE: begin
                if (cnt == CNT_W'(STROBE_CYCLES - 1)) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if ((op_mode == 2'b10) && (VRAM_GAP > 0)) begin
                    next_state = S_GAP;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(VRAM_GAP - 1)) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so each pin changes on the same
    // edge the sequencer enters the corresponding state. Mode and data are
    // loaded at pop time so they are already valid throughout SETUP, and they
    // are only ever reloaded by the next pop, which keeps them stable across
    // HOLD, GAP and IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_write    <= 1'b0;
            op_mode     <= 2'b00;
            op_data     <= 8'h00;
            vdp_mode    <= 2'b00;
            vdp_data_in <= 8'h00;
            vdp_read    <= 1'b0;
            vdp_write   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
        end else begin
            if (pop) begin
                op_write    <= head[10];
                op_mode     <= head[9:8];
                op_data     <= head[7:0];
                vdp_mode    <= head[9:8];
                vdp_data_in <= head[7:0];
            end
            // Mode 11 is reserved: it walks through the states but never strobes.
            vdp_write <= (next_state == S_STROBE) && op_write && (op_mode != 2'b11);
            vdp_read  <= (next_state == S_STROBE) && !op_write && (op_mode != 2'b11);
            rsp_valid <= (next_state == S_HOLD) && !op_write;
            // Capture on the last strobe cycle, i.e. the edge leaving STROBE.
            if ((state == S_STROBE) && (next_state == S_HOLD) && !op_write) begin
                rsp_data <= (op_mode == 2'b11) ? 8'h00 : vdp_data_out;
            end
        end
    end

endmodule
